// File: rtl/cas_player.sv
// Cassette playback engine: fetches bytes of a CAS image from tape RAM through a
// one-byte prefetch buffer and regenerates the FSK tape bit the console samples.
module cas_player #(
  parameter int ADDR_W = 18,
  parameter int HALF0  = 16,
  parameter int HALF1  = 8,
  parameter int LEADER = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              play,
  input  logic              rewind,
  input  logic [ADDR_W-1:0] tape_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  input  logic              mem_valid,
  output logic              data,
  output logic [ADDR_W-1:0] byte_count,
  output logic [2:0]        status
);

  // Handshake: mem_rd stays high with mem_addr stable up to and including the cycle
  // with mem_valid=1, which completes the read; mem_valid while mem_rd=0 is ignored.

  typedef enum logic [2:0] {S_IDLE, S_LEADER, S_START, S_BITS, S_WAIT, S_EOF} state_t;
  state_t state, state_n;

  logic [7:0]        tcnt, tcnt_n;
  logic [1:0]        half_idx, half_idx_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [15:0]       lead_cnt, lead_cnt_n;
  logic [7:0]        shreg, buf_q;
  logic              buf_full, loaded;
  logic              underrun, underrun_n, eof, playing, playing_n, data_n, byte_done;
  logic              in_bit, cur_bit, at_start, hold, step, half_end, bit_end, take, fill;
  logic [7:0]        half_len;
  logic [1:0]        last_half;
  logic [ADDR_W-1:0] byte_next;

  assign in_bit    = (state == S_LEADER) || (state == S_START) || (state == S_BITS);
  assign cur_bit   = (state == S_LEADER) || ((state == S_BITS) && shreg[bit_idx]);
  assign half_len  = cur_bit ? 8'(HALF1) : 8'(HALF0);
  assign last_half = cur_bit ? 2'd3 : 2'd1;
  // A bit that has not started yet is a pause point: play=0 holds it here.
  assign at_start  = (tcnt == 8'd0) && (half_idx == 2'd0);
  assign hold      = at_start && !play;
  assign step      = ce && in_bit && !hold;
  assign half_end  = (tcnt == half_len - 8'd1);
  assign bit_end   = step && half_end && (half_idx == last_half);
  assign take      = (state == S_START) && buf_full && !loaded && !hold;
  assign fill      = mem_rd && mem_valid;
  assign byte_next = byte_count + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset || rewind) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      half_idx   <= '0;
      bit_idx    <= 3'd7;
      lead_cnt   <= 16'(LEADER);
      shreg      <= '0;
      buf_q      <= '0;
      buf_full   <= 1'b0;
      loaded     <= 1'b0;
      underrun   <= 1'b0;
      eof        <= 1'b0;
      playing    <= 1'b0;
      data       <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      byte_count <= '0;
    end else begin
      state    <= state_n;
      tcnt     <= tcnt_n;
      half_idx <= half_idx_n;
      bit_idx  <= bit_idx_n;
      lead_cnt <= lead_cnt_n;
      underrun <= underrun_n;
      eof      <= (state_n == S_EOF);
      playing  <= playing_n;
      data     <= data_n;
      if (byte_done) begin
        byte_count <= byte_next;
        loaded     <= 1'b0;
      end
      if (fill) begin
        buf_q    <= mem_data;
        buf_full <= 1'b1;
        mem_rd   <= 1'b0;
        mem_addr <= mem_addr + ADDR_W'(1);
      end
      if (take) begin
        shreg    <= buf_q;
        loaded   <= 1'b1;
        buf_full <= 1'b0;
        if (mem_addr < tape_len) mem_rd <= 1'b1;
      end
      if ((state == S_IDLE) && play && (tape_len != '0)) mem_rd <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    tcnt_n     = tcnt;
    half_idx_n = half_idx;
    bit_idx_n  = bit_idx;
    lead_cnt_n = lead_cnt;
    underrun_n = underrun;
    byte_done  = 1'b0;
    if (step) begin
      if (half_end) begin
        tcnt_n     = '0;
        half_idx_n = bit_end ? 2'd0 : half_idx + 2'd1;
      end else begin
        tcnt_n = tcnt + 8'd1;
      end
    end
    case (state)
      S_IDLE: begin
        if (play) begin
          if (tape_len == '0)   state_n = S_EOF;
          else if (LEADER == 0) state_n = S_START;
          else                  state_n = S_LEADER;
        end
      end
      S_LEADER: begin
        if (bit_end) begin
          lead_cnt_n = lead_cnt - 16'd1;
          if (lead_cnt <= 16'd1) state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_idx_n = 3'd7;
          if (loaded || take) begin
            state_n = S_BITS;
          end else begin
            state_n    = S_WAIT;
            underrun_n = 1'b1;
          end
        end
      end
      S_BITS: begin
        if (bit_end) begin
          bit_idx_n = bit_idx - 3'd1;
          if (bit_idx == 3'd0) begin
            byte_done = 1'b1;
            // >= also catches tape_len shrinking below the bytes already sent.
            if (byte_next >= tape_len) begin
              state_n = S_EOF;
            end else if (buf_full || fill) begin
              state_n = S_START;
            end else begin
              state_n    = S_WAIT;
              underrun_n = 1'b1;
            end
          end
        end
      end
      S_WAIT: begin
        if (ce && play && (buf_full || fill)) state_n = S_START;
      end
      S_EOF: begin
        state_n = S_EOF;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    data_n = in_bit ? data : 1'b0;
    if (step) data_n = !half_idx[0];
    playing_n = (state_n inside {S_LEADER, S_START, S_BITS, S_WAIT}) &&
                (play || (tcnt_n != 8'd0) || (half_idx_n != 2'd0));
  end

  assign status = {eof, underrun, playing};

endmodule

// File: doc/cas_player.md
# cas_player

Parametrised cassette playback engine for the SVI328 core: streams a loaded CAS image from a byte-wide tape RAM and regenerates the FSK audio bit the console samples on its tape input. It supersedes the fixed-format cassette reader. It adds:
- configurable address width and pulse timing;
- one-byte prefetch buffering for gap-free output;
- an explicit end-of-tape length;
- pause at bit boundaries under motor control;
- a byte counter output for the OSD tape counter.

## Interface
Parameters:
- ADDR_W, 18, width of tape RAM address, tape_len and byte_count.
- HALF0, 16, ce ticks per half-period of a '0' bit; legal range 2..255.
- HALF1, 8, ce ticks per half-period of a '1' bit; legal range 1..255.
- LEADER, 64, number of '1' bits emitted before the first byte after a rewind.

Ports:
- clk  in  1  system clock; the only clock in the block.
- reset  in  1  synchronous, active-high.
- ce  in  1  tick enable; all pulse timing counts ce cycles only.
- play  in  1  level; high = motor on.
- rewind  in  1  synchronous restart to tape start; priority over play.
- tape_len  in  ADDR_W  number of valid bytes in the image; sampled continuously.
- mem_addr  out  ADDR_W  tape RAM byte address.
- mem_rd  out  1  read request.
- mem_data  in  8  read data.
- mem_valid  in  1  read acknowledge; mem_data is valid in this cycle.
- data  out  1  FSK output bit to the console.
- byte_count  out  ADDR_W  number of bytes fully transmitted.
- status  out  3  {eof, underrun_sticky, playing}.

## Operation
- State machine: IDLE, LEADER, START, BITS, WAIT, EOF.
- **reset or rewind** forces the following. Reset has priority over rewind; rewind has priority over everything else.
  - mem_addr=0, byte_count=0, buffer empty, leader count=LEADER.
  - state=IDLE, data=0, status=0, mem_rd=0.
- **IDLE**
  - play=1 and tape_len=0: go to EOF.
  - play=1 and tape_len>0: go to LEADER (or START if LEADER=0); issue a fetch of address 0 in the same transition.
- **Fetch handshake**
  - mem_rd rises and stays high, with mem_addr stable, until the cycle in which mem_valid=1.
  - In that cycle mem_data is loaded into the buffer; mem_rd drops the next cycle and mem_addr increments.
  - mem_valid while mem_rd=0 is ignored.
- **Bit encoding**
  - '0' bit: data=1 for HALF0 ticks, then data=0 for HALF0 ticks.
  - '1' bit: two full cycles of HALF1 ticks high and HALF1 ticks low.
- **LEADER**: emits leader-count '1' bits, then goes to START.
- **Byte frame**: a start bit '0', then the 8 data bits MSB first. START covers the start bit; BITS covers the data bits.
- **Prefetch**
  - Entering START moves the buffer into the shift register.
  - If mem_addr<tape_len, the next fetch is issued immediately.
- **End of each byte** (after data bit 0 completes)
  - byte_count increments.
  - byte_count==tape_len: go to EOF.
  - Buffer full: go to START.
  - Otherwise: go to WAIT, set underrun_sticky, hold data=0.
- **WAIT**: on buffer fill, go to START on the next ce.
- **Pause**: play=0 takes effect only at a bit boundary (the end of a full bit). The state, counters and buffer freeze with data=0; play=1 resumes with the next bit.
  - A fetch in flight always completes during a pause.
- **EOF**: data=0, eof=1; held until rewind or reset.
- **status**: playing=1 while in LEADER, START, BITS or WAIT and not paused.
- tape_len decreasing below byte_count mid-play: EOF at the next byte boundary.

## Timing
- All outputs are registered; every output is 0 after reset.
- IDLE plus play rising: mem_rd=1 on the next clk.
- data changes only on cycles with ce=1. The first high half of the leader begins on the first ce after entering LEADER.
- Byte period: (1+8) bit periods; bit period 2·HALF0 for a '0', 4·HALF1 for a '1'.
  - HALF0=2·HALF1 gives constant-length bits; no other relation is enforced.
- byte_count updates in the same cycle as the final low-to-boundary ce of data bit 0.
- rewind asserted mid-fetch: mem_rd drops next clk; the late mem_valid is ignored.

## Test plan
- Reset hold with play=1: all outputs 0; release reset, play=1, tape_len=0 -> eof=1 within 2 clk, data stays 0, mem_rd never high.
- HALF0=4, HALF1=2, LEADER=0, ce=1 always, image {0xA5}, mem_valid 1 clk after mem_rd:
  - data = start '0', then bits 1,0,1,0,0,1,0,1, for 72 clk total;
  - byte_count=1, then eof=1.
- Image {0x00,0xFF}, mem_valid delayed 3 clk: 18 bits emitted with no WAIT gap, underrun_sticky=0, byte_count=2.
- mem_valid delayed 200 clk, HALF0=4: after byte 0 data held 0, underrun_sticky=1, status.playing=1; transmission resumes on the ce after fill.
- play dropped mid-bit 3 of 0x5A: the current bit completes, then data=0 and byte_count frozen; play=1 resumes at bit 4 with identical waveform.
- rewind pulsed mid-byte 2 of a 4-byte image: next clk mem_addr=0, byte_count=0, data=0; the replay starts with LEADER '1' bits.
